// File: rtl/mipspipe_pkg.sv
// mipspipe_pkg
// Shared definitions for the EX-stage multiply/divide unit.
//   MD_MULT / MD_MULTU / MD_DIV / MD_DIVU : op encodings from the FunctEX decode
//   md_state_t                            : sequencer states (IDLE, RUN, FIX)
//   md_is_div / md_is_signed              : op decode helpers
package mipspipe_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // Bit 1 of the op separates divide from multiply.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Bit 0 clear means the signed variant (MULT / DIV).
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/md_step.sv
// md_step
// One combinational iteration of the unsigned multiply/divide datapath.
// The {acc,q} pair is the double-width working register.
//   is_div   in   1      1: restoring-divide step, 0: shift-add multiply step
//   acc_in   in   WIDTH  upper working half (partial product / partial remainder)
//   q_in     in   WIDTH  lower working half (multiplier bits / dividend-quotient bits)
//   b        in   WIDTH  multiplicand (mul) or divisor (div), unsigned
//   acc_out  out  WIDTH  next upper half
//   q_out    out  WIDTH  next lower half
module md_step
  import mipspipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  // Multiply: add the multiplicand when the current multiplier bit is set,
  // then shift the whole {carry,acc,q} right by one. After WIDTH steps
  // {acc,q} holds the full product.
  // Divide: shift {acc,q} left, try subtracting the divisor from the upper
  // half and keep the result only if it did not go negative. The carry bit
  // of the shifted partial remainder takes part in the compare; the
  // subtraction itself fits in WIDTH bits whenever it is kept.
  always_comb begin
    mul_sum   = {1'b0, acc_in} + (q_in[0] ? {1'b0, b} : '0);
    div_shift = {acc_in, q_in[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b});
    div_diff  = div_shift[WIDTH-1:0] - b;

    if (is_div) begin
      acc_out = div_ge ? div_diff : div_shift[WIDTH-1:0];
      q_out   = {q_in[WIDTH-2:0], div_ge};
    end else begin
      acc_out = mul_sum[WIDTH:1];
      q_out   = {mul_sum[0], q_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv
// Iterative MULT/MULTU/DIV/DIVU unit in the EX stage, owning the
// architectural HI/LO registers. One datapath step per clock; a result
// takes WIDTH+1 cycles from acceptance. busy stalls dependent instructions.
//   clk    in   1      clock, rising edge
//   reset  in   1      synchronous, active-low
//   start  in   1      issue a mul/div (sampled in IDLE only)
//   op     in   2      MD_MULT / MD_MULTU / MD_DIV / MD_DIVU
//   srcA   in   WIDTH  multiplicand / dividend
//   srcB   in   WIDTH  multiplier / divisor
//   flush  in   1      abandon the in-flight op, HI/LO untouched
//   mthi   in   1      write wdata to HI (IDLE only)
//   mtlo   in   1      write wdata to LO (IDLE only)
//   wdata  in   WIDTH  MTHI/MTLO data
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
//   busy   out  1      unit is not idle
//   done   out  1      one-cycle pulse when HI/LO take a new result
module ex_muldiv
  import mipspipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_t state, state_next;

  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] a_raw;
  logic             sign_a;
  logic             sign_b;
  logic             is_div;
  logic             div_zero;

  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] q_step;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             op_signed;

  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  md_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div  (is_div),
    .acc_in  (acc),
    .q_in    (q),
    .b       (b_reg),
    .acc_out (acc_step),
    .q_out   (q_step)
  );

  // The datapath is unsigned; signed ops run on magnitudes and the signs
  // are re-applied in FIX.
  always_comb begin
    op_signed = md_is_signed(op);
    abs_a     = (op_signed && srcA[WIDTH-1]) ? (~srcA + 1'b1) : srcA;
    abs_b     = (op_signed && srcB[WIDTH-1]) ? (~srcB + 1'b1) : srcB;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_next = IDLE;
        end else if (counter == LAST) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Sign fix-up. Remainder follows the dividend's sign, quotient the XOR of
  // both. The most-negative / -1 case needs no special handling: its
  // magnitude quotient 2^(WIDTH-1) negates to itself. A zero divisor gets a
  // defined result instead of whatever the iterations leave behind.
  always_comb begin
    product     = {acc, q};
    product_fix = (sign_a ^ sign_b) ? (~product + 1'b1) : product;
    quot_fix    = (sign_a ^ sign_b) ? (~q + 1'b1) : q;
    rem_fix     = sign_a ? (~acc + 1'b1) : acc;
    res_hi      = product_fix[2*WIDTH-1:WIDTH];
    res_lo      = product_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quot_fix;
      end
    end
  end

  // Operand capture, iteration and HI/LO write-back. MTHI/MTLO land in IDLE
  // even on the cycle an op is accepted; the op result overwrites later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      counter  <= '0;
      acc      <= '0;
      q        <= '0;
      b_reg    <= '0;
      a_raw    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) begin
            hi <= wdata;
          end
          if (mtlo) begin
            lo <= wdata;
          end
          if (start && !flush) begin
            counter  <= '0;
            acc      <= '0;
            a_raw    <= srcA;
            is_div   <= md_is_div(op);
            div_zero <= (srcB == '0);
            sign_a   <= md_is_signed(op) & srcA[WIDTH-1];
            sign_b   <= md_is_signed(op) & srcB[WIDTH-1];
            if (md_is_div(op)) begin
              q     <= abs_a;
              b_reg <= abs_b;
            end else begin
              q     <= abs_b;
              b_reg <= abs_a;
            end
          end
        end
        RUN: begin
          if (!flush) begin
            acc     <= acc_step;
            q       <= q_step;
            counter <= (counter == LAST) ? '0 : counter + 1'b1;
          end
        end
        FIX: begin
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
